relu_maxpool: RTL and testbench

Post-accumulator stage of one systolic-array column. It consumes the saturated 8-bit convolution results that the accumulator emits in 2x2 pooling-window order (four consecutive beats per window) and applies ReLU and 2x2 max pooling. It buffers the pooled pixels in a small FIFO and presents them to the output buffer writer with a valid/ready handshake. The upstream side has no backpressure, so this block absorbs bursts and flags any loss.

---
 rtl/relu_maxpool.sv | 132 +++++++++++++
 tb/tb_relu_maxpool.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool.sv
// ReLU + 2x2 max pooling for one systolic-array column, with a small output FIFO.
// Pooled pixels leave through a valid/ready handshake; upstream overruns are flagged.
module relu_maxpool #(
    parameter int FIFO_DEPTH = 8,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              conv_valid_i,
    input  logic              conv_last_i,
    input  logic signed [7:0] conv_data_i,
    input  logic              clr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic signed [7:0] out_data_o,
    output logic              out_last_o,
    output logic [7:0]        out_index_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              frame_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state_q;
    logic [1:0]        bcnt_q;
    logic signed [7:0] max_q;
    logic [7:0]        idx_q;
    logic              overflow_q;
    logic              frame_err_q;

    logic [16:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;

    logic signed [7:0] relu_v;
    logic signed [7:0] cur_max;
    logic              push;
    logic              push_last;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;
    logic [16:0]       head;

    always_comb begin
        relu_v    = (RELU_EN && conv_data_i[7]) ? 8'sd0 : conv_data_i;
        cur_max   = (bcnt_q == 2'd0 || relu_v > max_q) ? relu_v : max_q;
        push      = conv_valid_i && (bcnt_q == 2'd3 || conv_last_i);
        push_last = conv_valid_i && conv_last_i;
        pop       = (count_q != '0) && out_ready_i;
        full      = (count_q == FULL_CNT);
        // A simultaneous pop frees the slot, so a full FIFO can still take the push.
        accept    = push && (!full || pop);
        drop      = push && !accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {cur_max, conv_last_i, idx_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bcnt_q      <= 2'd0;
            max_q       <= 8'sd0;
            idx_q       <= 8'd0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (conv_valid_i) begin
                max_q  <= cur_max;
                bcnt_q <= conv_last_i ? 2'd0 : bcnt_q + 2'd1;
            end
            // Clear first so that a coincident set event takes priority.
            if (clr_i) begin
                overflow_q  <= 1'b0;
                frame_err_q <= 1'b0;
                idx_q       <= 8'd0;
            end
            if (push)                                    idx_q       <= conv_last_i ? 8'd0 : idx_q + 8'd1;
            if (drop)                                    overflow_q  <= 1'b1;
            if (push_last && bcnt_q != 2'd3)             frame_err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (conv_valid_i) state_q <= push_last ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (push_last) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (conv_valid_i)         state_q <= push_last ? S_DRAIN : S_RUN;
                    else if (count_q == '0)   state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        head        = mem_q[rd_ptr_q];
        out_valid_o = (count_q != '0);
        out_data_o  = out_valid_o ? head[16:9] : 8'sd0;
        out_last_o  = out_valid_o ? head[8]    : 1'b0;
        out_index_o = out_valid_o ? head[7:0]  : 8'd0;
        busy_o      = (state_q != S_IDLE) || (count_q != '0);
        overflow_o  = overflow_q;
        frame_err_o = frame_err_q;
    end
endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: stimulus pushes expected pixels, a monitor pops
// and compares on every output handshake. A second instance exercises RELU_EN=0.
module tb_relu_maxpool;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              conv_valid;
    logic              raw_valid;
    logic              conv_last;
    logic signed [7:0] conv_data;
    logic              clr;
    logic              out_ready;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_last;
    logic [7:0]        out_index;
    logic              busy;
    logic              overflow;
    logic              frame_err;

    logic              raw_clr = 1'b0;
    logic              raw_ready = 1'b1;
    logic              raw_out_valid;
    logic signed [7:0] raw_out_data;
    logic              raw_out_last;
    logic [7:0]        raw_out_index;
    logic              raw_busy;
    logic              raw_overflow;
    logic              raw_frame_err;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t raw_q[$];
    exp_t e_main, g_main, e_raw, g_raw;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    relu_maxpool #(.FIFO_DEPTH(8), .RELU_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .conv_valid_i(conv_valid), .conv_last_i(conv_last),
        .conv_data_i(conv_data), .clr_i(clr), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_last_o(out_last), .out_index_o(out_index), .busy_o(busy),
        .overflow_o(overflow), .frame_err_o(frame_err)
    );

    relu_maxpool #(.FIFO_DEPTH(8), .RELU_EN(1'b0)) u_raw (
        .clk(clk), .rst_n(rst_n), .conv_valid_i(raw_valid), .conv_last_i(conv_last),
        .conv_data_i(conv_data), .clr_i(raw_clr), .out_valid_o(raw_out_valid), .out_ready_i(raw_ready),
        .out_data_o(raw_out_data), .out_last_o(raw_out_last), .out_index_o(raw_out_index), .busy_o(raw_busy),
        .overflow_o(raw_overflow), .frame_err_o(raw_frame_err)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int d, input bit l, input int i);
        exp_t e;
        e.data = 8'(d);
        e.last = l;
        e.idx  = 8'(i);
        return e;
    endfunction

    // Monitor: compare every accepted head against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                g_main = {out_data, out_last, out_index};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL main_unexpected actual idx %0d data %0d required none", out_index, out_data);
                end else begin
                    e_main = exp_q.pop_front();
                    if (g_main !== e_main) begin
                        errors++;
                        $display("FAIL main_pixel actual data %0d last %0d idx %0d required data %0d last %0d idx %0d",
                                 $signed(g_main.data), g_main.last, g_main.idx,
                                 $signed(e_main.data), e_main.last, e_main.idx);
                    end else begin
                        $display("main pixel idx %0d data %0d last %0d", g_main.idx, $signed(g_main.data), g_main.last);
                    end
                end
            end
            if (rst_n && raw_out_valid && raw_ready) begin
                g_raw = {raw_out_data, raw_out_last, raw_out_index};
                checks++;
                if (raw_q.size() == 0) begin
                    errors++;
                    $display("FAIL raw_unexpected actual idx %0d data %0d required none", raw_out_index, raw_out_data);
                end else begin
                    e_raw = raw_q.pop_front();
                    if (g_raw !== e_raw) begin
                        errors++;
                        $display("FAIL raw_pixel actual data %0d last %0d idx %0d required data %0d last %0d idx %0d",
                                 $signed(g_raw.data), g_raw.last, g_raw.idx,
                                 $signed(e_raw.data), e_raw.last, e_raw.idx);
                    end else begin
                        $display("raw pixel idx %0d data %0d last %0d", g_raw.idx, $signed(g_raw.data), g_raw.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit raw, input logic signed [7:0] d, input bit l);
        conv_data = d;
        conv_last = l;
        if (raw) raw_valid = 1'b1;
        else     conv_valid = 1'b1;
        tick();
        conv_valid = 1'b0;
        raw_valid  = 1'b0;
        conv_last  = 1'b0;
    endtask

    task automatic send_win(input bit raw, input int a, input int b, input int c, input int d, input bit l);
        send(raw, 8'(a), 1'b0);
        send(raw, 8'(b), 1'b0);
        send(raw, 8'(c), 1'b0);
        send(raw, 8'(d), l);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid || raw_q.size() != 0 || raw_out_valid) && n < 60) begin
            tick();
            n++;
        end
        check(name, int'(n < 60), 1);
    endtask

    initial begin
        int vals[16] = '{1, 2, 3, 4, -10, 20, -30, 5, 100, -100, 50, 99, -7, -8, -9, 127};
        rst_n = 1'b0; conv_valid = 1'b0; raw_valid = 1'b0; conv_last = 1'b0;
        conv_data = 8'sd0; clr = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_index", out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick();

        // Single window, ReLU, pixel lands the cycle after beat 3.
        exp_q.push_back(mk(7, 1, 0));
        send_win(0, -5, 3, 7, -128, 1);
        check("t1_latency_valid", out_valid, 1);
        check("t1_busy_head", busy, 1);
        tick();
        check("t1_popped", out_valid, 0);
        check("t1_busy_after_pop", busy, 1);
        tick();
        check("t1_busy_fall", busy, 0);

        // All-negative window under both ReLU settings.
        exp_q.push_back(mk(0, 1, 0));
        send_win(0, -1, -2, -3, -4, 1);
        raw_q.push_back(mk(-1, 1, 0));
        send_win(1, -1, -2, -3, -4, 1);
        drain("t2_drain");

        // 4x4 map pooled to four pixels at full input rate.
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back(mk(w == 0 ? 4 : w == 1 ? 20 : w == 2 ? 100 : 127, w == 3, w));
        end
        for (int i = 0; i < 16; i++) begin
            send(0, 8'(vals[i]), i == 15);
            if (i % 4 == 3) begin
                check("t3_latency_valid", out_valid, 1);
                check("t3_head_index", out_index, i / 4);
            end
        end
        drain("t3_drain");

        // Overflow: 9 windows into an 8-deep FIFO with no downstream ready.
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back(mk(k + 1, 0, k));
            send_win(0, -1, k + 1, -2, 0, k == 8);
        end
        check("t4_overflow_set", overflow, 1);
        check("t4_head_valid", out_valid, 1);
        repeat (3) tick();
        check("t4_head_stable_idx", out_index, 0);
        check("t4_head_stable_data", out_data, 1);
        check("t4_busy_full", busy, 1);
        out_ready = 1'b1;
        drain("t4_drain");
        check("t4_overflow_sticky", overflow, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_overflow_clr", overflow, 0);
        check("t4_busy_idle", busy, 0);

        // Full FIFO with a pop coinciding with the 9th push: nothing lost.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(k + 10, 0, k));
            send_win(0, k + 10, -3, 0, 1, 0);
        end
        exp_q.push_back(mk(18, 1, 8));
        send(0, 8'sd18, 1'b0);
        send(0, -8'sd3, 1'b0);
        send(0, 8'sd0, 1'b0);
        out_ready = 1'b1;
        send(0, 8'sd1, 1'b1);
        check("t5_no_overflow", overflow, 0);
        drain("t5_drain");

        // Early last on beat 1, then a clean frame restarting at beat 0 / index 0.
        exp_q.push_back(mk(9, 1, 0));
        send(0, 8'sd4, 1'b0);
        send(0, 8'sd9, 1'b1);
        check("t6_frame_err", frame_err, 1);
        exp_q.push_back(mk(5, 1, 0));
        send_win(0, 1, 2, 3, 5, 1);
        check("t6_frame_err_sticky", frame_err, 1);
        drain("t6_drain");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_frame_err_clr", frame_err, 0);

        // Reset mid-window discards the partial window.
        send(0, 8'sd100, 1'b0);
        send(0, 8'sd100, 1'b0);
        send(0, 8'sd100, 1'b0);
        rst_n = 1'b0;
        tick();
        check("t7_rst_valid", out_valid, 0);
        rst_n = 1'b1;
        exp_q.push_back(mk(2, 1, 0));
        send_win(0, 1, 1, 1, 2, 1);
        drain("t7_drain");

        check("end_main_queue", exp_q.size(), 0);
        check("end_raw_queue", raw_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
